// File: rtl/chip8_fetch_if.sv
// Fetch-unit bus: control requests, program RAM read port and decoded-opcode outputs.
interface chip8_fetch_if;
  logic        fetch;
  logic        pc_load;
  logic [11:0] pc_target;
  logic        skip;
  logic [11:0] mem_addr;
  logic        mem_rd;
  logic [7:0]  mem_data;
  logic [15:0] opcode;
  logic [11:0] opcode_pc;
  logic        opcode_valid;
  logic [11:0] pc;
  logic        busy;

  // Fetch unit side
  modport slave (
    input  fetch, pc_load, pc_target, skip, mem_data,
    output mem_addr, mem_rd, opcode, opcode_pc, opcode_valid, pc, busy
  );

  // Control unit / RAM side
  modport master (
    output fetch, pc_load, pc_target, skip, mem_data,
    input  mem_addr, mem_rd, opcode, opcode_pc, opcode_valid, pc, busy
  );
endinterface

// File: rtl/chip8_fetch.sv
// CHIP-8 instruction fetch: owns the PC, reads two bytes big-endian from
// byte-wide RAM and emits a one-cycle opcode_valid pulse with the opcode.
module chip8_fetch #(
  parameter logic [11:0] RESET_PC = 12'h200
) (
  input  logic           clk,
  input  logic           rst_n,
  chip8_fetch_if.slave   bus
);

  typedef enum logic [1:0] {IDLE, RD_HI, RD_LO, WAIT_LO} state_t;

  state_t      state;
  logic [11:0] pc;
  logic [11:0] mem_addr;
  logic        mem_rd;
  logic [15:0] opcode;
  logic [11:0] opcode_pc;
  logic        opcode_valid;
  logic [7:0]  hi;
  logic [11:0] eff_pc;

  // PC after this cycle's jump/skip request; pc_load wins over skip
  always_comb begin
    eff_pc = pc;
    if (bus.pc_load)
      eff_pc = bus.pc_target;
    else if (bus.skip)
      eff_pc = pc + 12'd2;
  end

  // Fetch sequencer: all outputs registered, PC arithmetic wraps at 4096
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      pc           <= RESET_PC;
      mem_addr     <= '0;
      mem_rd       <= 1'b0;
      opcode       <= '0;
      opcode_pc    <= '0;
      opcode_valid <= 1'b0;
      hi           <= '0;
    end else begin
      opcode_valid <= 1'b0;
      case (state)
        IDLE: begin
          pc <= eff_pc;
          if (bus.fetch) begin
            mem_addr <= eff_pc;
            mem_rd   <= 1'b1;
            state    <= RD_HI;
          end
        end
        RD_HI: begin
          mem_addr <= pc + 12'd1;
          state    <= RD_LO;
        end
        RD_LO: begin
          hi     <= bus.mem_data;
          mem_rd <= 1'b0;
          state  <= WAIT_LO;
        end
        WAIT_LO: begin
          opcode       <= {hi, bus.mem_data};
          opcode_pc    <= pc;
          pc           <= pc + 12'd2;
          opcode_valid <= 1'b1;
          state        <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.mem_addr     = mem_addr;
  assign bus.mem_rd       = mem_rd;
  assign bus.opcode       = opcode;
  assign bus.opcode_pc    = opcode_pc;
  assign bus.opcode_valid = opcode_valid;
  assign bus.pc           = pc;
  assign bus.busy         = (state != IDLE);

endmodule
